jpeg_stream_packer: RTL and testbench

- Synthesizable sink for the JPEG encoder output bitstream.
- Accepts the encoder's 32-bit word stream, including the final partial word flagged at end of file with its valid-bit count.
- Buffers words in a FIFO and re-serialises them onto a parametrised-width ready/valid byte-lane stream, padding the final byte with 1s per JPEG.
- Sits between jpeg_top and the host/DMA interface; replaces file-dump capture for on-chip bitstream delivery.

---
 rtl/jpeg_stream_packer.sv | 257 +++++++++++++++++++++++++
 tb/tb_jpeg_stream_packer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_stream_packer.sv
// jpeg_stream_packer: output sink for the JPEG encoder bitstream.
// The encoder's 32-bit words go through a one-word write stage, then a FIFO.
// They are sent out again as an MSB-first ready/valid byte-lane stream.
// The final partial word is padded with 1s in its last valid byte.
// Optional feature macro: JPEG_EOI_APPEND_EN appends the 0xFF,0xD9 EOI marker
// after the last entry and moves out_last onto it.
// Handshake: a beat transfers on a rising edge where out_valid && out_ready.
// While stalled, out_data/out_keep/out_last hold, and out_valid only drops
// after a transfer or on reset.
module jpeg_stream_packer #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [IN_W-1:0]        in_data,
    input  logic                   in_valid,
    input  logic [CNT_W-1:0]       eof_count,
    input  logic                   eof_partial,
    output logic [OUT_W-1:0]       out_data,
    output logic [OUT_W/8-1:0]     out_keep,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic                   ovf_err,
    output logic                   proto_err
);
    localparam int LANES = OUT_W / 8;
    localparam int IN_B  = IN_W / 8;
    localparam int AW    = $clog2(DEPTH);
    localparam int NB_W  = $clog2(IN_B + 1);
    localparam logic [AW:0]   FULL_LVL = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1
`ifdef JPEG_EOI_APPEND_EN
        , S_TAIL = 2'd2
`endif
    } state_t;

    state_t state, state_nx;

    // Write stage: the registered word with its padding and byte count applied.
    logic            w_valid, w_last;
    logic [IN_W-1:0] w_data, pad_data;
    logic [NB_W-1:0] w_nb, pad_nb;

    // FIFO storage. The head entry stays counted until its final beat is accepted.
    logic [IN_W-1:0] mem_data [DEPTH];
    logic [NB_W-1:0] mem_nb   [DEPTH];
    logic            mem_last [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr, nx_ptr;
    logic [AW:0]     count;
    logic            push, pop;

    // Shift register holding the entry being emitted.
    logic [IN_W-1:0] sh_data;
    logic [NB_W-1:0] sh_rem;
    logic            sh_last;
    logic            beat_final, load_head, load_next, shift_beat;
`ifdef JPEG_EOI_APPEND_EN
    logic            tail_idx, tail_final;
    logic [OUT_W+15:0] eoi_word;
    assign eoi_word   = {16'hFFD9, {OUT_W{1'b0}}};
    assign tail_final = (LANES > 1) || tail_idx;
`endif

    assign nx_ptr     = rd_ptr + PTR_ONE;
    assign fill_level = count;
    assign beat_final = (sh_rem <= NB_W'(LANES));
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    assign push       = w_valid && ((count != FULL_LVL) || pop);

    // Byte count and 1-padding of the final partial word's last valid byte.
    always_comb begin
        pad_nb   = NB_W'((int'(eof_count) + 7) / 8);
        pad_data = in_data;
        for (int i = 0; i < IN_W; i++) begin
            if ((i < IN_W - int'(eof_count)) && (i >= IN_W - 8 * int'(pad_nb)))
                pad_data[i] = 1'b1;
        end
    end

    // Capture the incoming word. A partial word wins over a full word in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_valid   <= 1'b0;
            w_data    <= '0;
            w_nb      <= '0;
            w_last    <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            w_valid <= in_valid | eof_partial;
            if (eof_partial) begin
                w_data <= pad_data;
                w_nb   <= pad_nb;
                w_last <= 1'b1;
            end else begin
                w_data <= in_data;
                w_nb   <= NB_W'(IN_B);
                w_last <= 1'b0;
            end
            if (in_valid && eof_partial)
                proto_err <= 1'b1;
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= w_data;
            mem_nb[wr_ptr]   <= w_nb;
            mem_last[wr_ptr] <= w_last;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= nx_ptr;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (w_valid && !push)
                ovf_err <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Next-state and datapath strobes. On an entry's final beat, the next entry loads directly.
    always_comb begin
        state_nx   = state;
        load_head  = 1'b0;
        load_next  = 1'b0;
        shift_beat = 1'b0;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    load_head = 1'b1;
                    state_nx  = S_EMIT;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (!beat_final) begin
                        shift_beat = 1'b1;
                    end else begin
                        pop = 1'b1;
                        if (sh_last) begin
`ifdef JPEG_EOI_APPEND_EN
                            state_nx = S_TAIL;
`else
                            state_nx = S_IDLE;
`endif
                        end else if (|count[AW:1]) begin
                            load_next = 1'b1;
                        end else begin
                            state_nx = S_IDLE;
                        end
                    end
                end
            end
`ifdef JPEG_EOI_APPEND_EN
            S_TAIL: begin
                if (out_ready && tail_final)
                    state_nx = S_IDLE;
            end
`endif
            default: state_nx = S_IDLE;
        endcase
    end

    // Shift register load and advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_data <= '0;
            sh_rem  <= '0;
            sh_last <= 1'b0;
        end else if (load_head) begin
            sh_data <= mem_data[rd_ptr];
            sh_rem  <= mem_nb[rd_ptr];
            sh_last <= mem_last[rd_ptr];
        end else if (load_next) begin
            sh_data <= mem_data[nx_ptr];
            sh_rem  <= mem_nb[nx_ptr];
            sh_last <= mem_last[nx_ptr];
        end else if (shift_beat) begin
            sh_data <= sh_data << OUT_W;
            sh_rem  <= sh_rem - NB_W'(LANES);
        end
    end

`ifdef JPEG_EOI_APPEND_EN
    // Tracks which EOI byte is presented when the lane is a single byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tail_idx <= 1'b0;
        else if (state == S_TAIL && out_ready)
            tail_idx <= !tail_final;
    end
`endif

    // Beat outputs decoded from state and shift register.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_keep  = '0;
        out_last  = 1'b0;
        case (state)
            S_EMIT: begin
                out_valid = 1'b1;
                out_data  = sh_data[IN_W-1 -: OUT_W];
                for (int k = 0; k < LANES; k++)
                    out_keep[LANES-1-k] = (int'(sh_rem) > k);
`ifdef JPEG_EOI_APPEND_EN
                out_last = 1'b0;
`else
                out_last = beat_final & sh_last;
`endif
            end
`ifdef JPEG_EOI_APPEND_EN
            S_TAIL: begin
                out_valid = 1'b1;
                out_data  = tail_idx ? eoi_word[OUT_W+7 -: OUT_W] : eoi_word[OUT_W+15 -: OUT_W];
                for (int k = 0; k < LANES; k++)
                    out_keep[LANES-1-k] = (k < 2);
                out_last = tail_final;
            end
`endif
            default: ;
        endcase
    end
endmodule

// File: tb/tb_jpeg_stream_packer.sv
// tb_jpeg_stream_packer: three packer instances.
// u8 uses the defaults. u32 has OUT_W=32 and DEPTH=4. u16 has OUT_W=16.
// u8 beats are compared against a byte-level reference model queue.
`timescale 1ns/1ps
module tb_jpeg_stream_packer;
`ifdef JPEG_EOI_APPEND_EN
    localparam bit EOI = 1'b1;
`else
    localparam bit EOI = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] in_data8;  logic in_valid8;  logic [4:0] eof_count8;  logic eof_partial8;
    logic [7:0]  out_data8; logic [0:0] out_keep8; logic out_last8, out_valid8, out_ready8;
    logic [4:0]  fill8;     logic ovf8, proto8;

    logic [31:0] in_data32;  logic in_valid32;  logic [4:0] eof_count32;  logic eof_partial32;
    logic [31:0] out_data32; logic [3:0] out_keep32; logic out_last32, out_valid32, out_ready32;
    logic [2:0]  fill32;     logic ovf32, proto32;

    logic [31:0] in_data16;  logic in_valid16;  logic [4:0] eof_count16;  logic eof_partial16;
    logic [15:0] out_data16; logic [1:0] out_keep16; logic out_last16, out_valid16, out_ready16;
    logic [4:0]  fill16;     logic ovf16, proto16;

    jpeg_stream_packer u8 (
        .clk(clk), .rst(rst), .in_data(in_data8), .in_valid(in_valid8),
        .eof_count(eof_count8), .eof_partial(eof_partial8), .out_data(out_data8),
        .out_keep(out_keep8), .out_last(out_last8), .out_valid(out_valid8),
        .out_ready(out_ready8), .fill_level(fill8), .ovf_err(ovf8), .proto_err(proto8)
    );

    jpeg_stream_packer #(.OUT_W(32), .DEPTH(4)) u32 (
        .clk(clk), .rst(rst), .in_data(in_data32), .in_valid(in_valid32),
        .eof_count(eof_count32), .eof_partial(eof_partial32), .out_data(out_data32),
        .out_keep(out_keep32), .out_last(out_last32), .out_valid(out_valid32),
        .out_ready(out_ready32), .fill_level(fill32), .ovf_err(ovf32), .proto_err(proto32)
    );

    jpeg_stream_packer #(.OUT_W(16)) u16 (
        .clk(clk), .rst(rst), .in_data(in_data16), .in_valid(in_valid16),
        .eof_count(eof_count16), .eof_partial(eof_partial16), .out_data(out_data16),
        .out_keep(out_keep16), .out_last(out_last16), .out_valid(out_valid16),
        .out_ready(out_ready16), .fill_level(fill16), .ovf_err(ovf16), .proto_err(proto16)
    );

    int checks = 0;
    int errors = 0;
    // Expected u8 beats: {data, keep, last}; data is 0 where keep is 0.
    logic [9:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: the byte sequence one input event must produce.
    task automatic model8(input logic [31:0] d, input logic full, input logic part, input int cnt);
        int nb;
        int padw;
        logic [7:0] b;
        if (part) begin
            nb = (cnt + 7) / 8;
            if (nb == 0)
                exp_q.push_back({8'h00, 1'b0, !EOI});
            for (int i = 0; i < nb; i++) begin
                b = 8'((d >> (24 - 8 * i)) & 32'hFF);
                if (i == nb - 1) begin
                    padw = 8 * nb - cnt;
                    b = b | 8'((1 << padw) - 1);
                end
                exp_q.push_back({b, 1'b1, (i == nb - 1) && !EOI});
            end
            if (EOI) begin
                exp_q.push_back({8'hFF, 1'b1, 1'b0});
                exp_q.push_back({8'hD9, 1'b1, 1'b1});
            end
        end else if (full) begin
            for (int i = 0; i < 4; i++)
                exp_q.push_back({8'((d >> (24 - 8 * i)) & 32'hFF), 1'b1, 1'b0});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic [31:0] d, input logic v, input logic p, input int cnt);
        in_data8     = d;
        in_valid8    = v;
        eof_partial8 = p;
        eof_count8   = 5'(cnt);
        model8(d, v, p, cnt);
    endtask

    task automatic idle8();
        in_valid8    = 1'b0;
        eof_partial8 = 1'b0;
        eof_count8   = '0;
    endtask

    task automatic drain8(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid8) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("u8_drain_done", exp_q.size(), 0);
        step();
    endtask

    // u8 scoreboard: compare every accepted beat and check stalled beats hold.
    logic       prev_stall;
    logic [9:0] prev_beat;
    logic [9:0] obs_beat;
    logic [9:0] exp_beat;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            obs_beat = {out_keep8[0] ? out_data8 : 8'h00, out_keep8, out_last8};
            if (prev_stall) begin
                check("u8_hold_valid", out_valid8, 1'b1);
                check("u8_hold_beat", {out_data8, out_keep8, out_last8}, prev_beat);
            end
            if (out_valid8 && out_ready8) begin
                check("u8_beat_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    exp_beat = exp_q.pop_front();
                    check("u8_beat", obs_beat, exp_beat);
                end
            end
            prev_stall = out_valid8 && !out_ready8;
            prev_beat  = {out_data8, out_keep8, out_last8};
        end
    end

    logic [7:0]  t1_bytes [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    logic [31:0] w32 [5] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};

    initial begin
        int   beats;
        bit   found;
        bit   part;
        logic [31:0] rw;

        rst = 1'b1;
        idle8();
        in_data8 = '0; out_ready8 = 1'b0;
        in_data32 = '0; in_valid32 = 1'b0; eof_count32 = '0; eof_partial32 = 1'b0; out_ready32 = 1'b0;
        in_data16 = '0; in_valid16 = 1'b0; eof_count16 = '0; eof_partial16 = 1'b0; out_ready16 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid8, 1'b0);
        check("rst_out_last", out_last8, 1'b0);
        check("rst_out_keep", out_keep8, 1'b0);
        check("rst_out_data", out_data8, 8'h00);
        check("rst_fill", fill8, 5'd0);
        check("rst_ovf", ovf8, 1'b0);
        check("rst_proto", proto8, 1'b0);
        rst = 1'b0;
        step();

        // Two full words, ready high: latency and back-to-back bytes.
        out_ready8 = 1'b1;
        drive8(32'h12345678, 1'b1, 1'b0, 0);
        step();
        drive8(32'h9ABCDEF0, 1'b1, 1'b0, 0);
        step();
        idle8();
        @(negedge clk);
        check("t1_lat_not_yet", out_valid8, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t1_valid", out_valid8, 1'b1);
            check("t1_byte", out_data8, t1_bytes[i]);
        end
        drain8(50);

        // Final partial word of 11 bits: padding and last marker.
        drive8(32'hA5C00000, 1'b0, 1'b1, 11);
        step();
        idle8();
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            found = out_valid8 && out_last8;
        end
        check("t2_last_seen", found, 1'b1);
        check("t2_last_byte", out_data8, EOI ? 8'hD9 : 8'hDF);
        drain8(50);

        // Full and partial together: partial wins, protocol error flagged.
        drive8(32'h77000000, 1'b1, 1'b1, 8);
        step();
        idle8();
        drain8(50);
        check("t3_proto", proto8, 1'b1);

        // Empty final word: a keep-less last beat.
        drive8(32'hDEADBEEF, 1'b0, 1'b1, 0);
        step();
        idle8();
        drain8(50);

        // Randomized traffic with random backpressure.
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(3, 10)) begin
                out_ready8 = ($urandom_range(0, 3) != 0);
                step();
            end
            part = ($urandom_range(0, 4) == 0);
            rw   = $urandom;
            drive8(rw, !part, part, int'($urandom_range(0, 31)));
            out_ready8 = ($urandom_range(0, 3) != 0);
            step();
            idle8();
        end
        out_ready8 = 1'b1;
        drain8(2000);
        check("rand_no_ovf", ovf8, 1'b0);

        // Reset with three entries queued, then a clean restart.
        out_ready8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive8(32'hC0DE0000 + 32'(i), 1'b1, 1'b0, 0);
            step();
        end
        idle8();
        repeat (4) step();
        check("mr_fill3", fill8, 5'd3);
        check("mr_valid_before", out_valid8, 1'b1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("mr_valid0", out_valid8, 1'b0);
        check("mr_fill0", fill8, 5'd0);
        step();
        step();
        rst = 1'b0;
        out_ready8 = 1'b1;
        step();
        drive8(32'h01020304, 1'b1, 1'b0, 0);
        step();
        idle8();
        drain8(50);

        // Overflow on the 32-bit, depth-4 instance.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid32 = 1'b1;
            in_data32  = w32[i];
        end
        @(negedge clk);
        in_valid32 = 1'b0;
        repeat (4) @(negedge clk);
        check("u32_fill_full", fill32, 3'd4);
        check("u32_ovf", ovf32, 1'b1);
        out_ready32 = 1'b1;
        beats = 0;
        for (int c = 0; c < 16; c++) begin
            if (out_valid32) begin
                if (beats < 4) begin
                    check("u32_word", out_data32, w32[beats]);
                    check("u32_keep", out_keep32, 4'b1111);
                end
                beats++;
            end
            @(negedge clk);
        end
        check("u32_beat_count", beats, 4);
        check("u32_fill_empty", fill32, 3'd0);

        // 16-bit lanes with a two-cycle stall on the second beat.
        @(negedge clk);
        in_valid16 = 1'b1;
        in_data16  = 32'hCAFEBABE;
        @(negedge clk);
        in_valid16 = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            found = out_valid16;
        end
        check("u16_valid_seen", found, 1'b1);
        check("u16_beat0", {out_data16, out_keep16, out_last16}, {16'hCAFE, 2'b11, 1'b0});
        out_ready16 = 1'b1;
        @(negedge clk);
        check("u16_beat1", {out_data16, out_keep16, out_last16}, {16'hBABE, 2'b11, 1'b0});
        out_ready16 = 1'b0;
        @(negedge clk);
        check("u16_hold1_valid", out_valid16, 1'b1);
        check("u16_hold1", {out_data16, out_keep16, out_last16}, {16'hBABE, 2'b11, 1'b0});
        @(negedge clk);
        check("u16_hold2", {out_data16, out_keep16, out_last16}, {16'hBABE, 2'b11, 1'b0});
        out_ready16 = 1'b1;
        @(negedge clk);
        check("u16_done", out_valid16, 1'b0);
        out_ready16 = 1'b0;

        check("u8_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
